// File: rtl/link_tx_arbiter.sv
// Round-robin arbiter sharing one link sender between NUM_REQ requesters; LINK_ARB_PRIO_EN makes requester 0 strict-priority.
// Latency: req_i sampled at edge N -> tx_start_o/gnt_o high after edge N; ack_o pulses the cycle after tx_done_i is sampled.
// Backpressure: a word is held until tx_done_i or TIMEOUT cycles expire; no new grant until tx_done_i drops again.
module link_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      tx_start_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_done_i,
    output logic                      busy_o,
    output logic                      err_timeout_o,
    output logic [15:0]               word_cnt_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       win_q, win_d;
    logic                prio_q, prio_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [NUM_REQ-1:0]  gnt_d, ack_d;
    logic                start_d, err_d;
    logic [DATA_W-1:0]   data_d;
    logic [15:0]         cnt_d;

    logic [DATA_W-1:0]   words [NUM_REQ];
    logic [PW-1:0]       arb_win;
    logic                arb_found, arb_prio;
    logic [PW:0]         scan_sum;
    logic [PW-1:0]       scan_idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = data_i[i*DATA_W +: DATA_W];
        end
    end

    // First requester at or above the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_prio  = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (scan_sum >= (PW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (PW+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!arb_found && req_i[scan_idx]) begin
                arb_found = 1'b1;
                arb_win   = scan_idx;
            end
        end
`ifdef LINK_ARB_PRIO_EN
        if (req_i[0]) begin
            arb_win  = '0;
            arb_prio = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        prio_d  = prio_q;
        tcnt_d  = tcnt_q;
        gnt_d   = gnt_o;
        ack_d   = '0;
        start_d = tx_start_o;
        data_d  = tx_data_o;
        err_d   = err_timeout_o;
        cnt_d   = word_cnt_o;
        case (state_q)
            IDLE: begin
                if (en && arb_found) begin
                    win_d   = arb_win;
                    prio_d  = arb_prio;
                    data_d  = words[arb_win];
                    gnt_d   = NUM_REQ'(1) << arb_win;
                    start_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_done_i || (tcnt_q == T_LAST)) begin
                    start_d = 1'b0;
                    gnt_d   = '0;
                    state_d = RELEASE;
                    // A priority win leaves the rotation where it was.
                    if (!prio_q) begin
                        ptr_d = (win_q == P_LAST) ? '0 : win_q + PW'(1);
                    end
                    if (tx_done_i) begin
                        ack_d = NUM_REQ'(1) << win_q;
                        cnt_d = word_cnt_o + 16'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            RELEASE: begin
                if (!tx_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            prio_q        <= 1'b0;
            tcnt_q        <= '0;
            gnt_o         <= '0;
            ack_o         <= '0;
            tx_start_o    <= 1'b0;
            tx_data_o     <= '0;
            err_timeout_o <= 1'b0;
            word_cnt_o    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            prio_q        <= prio_d;
            tcnt_q        <= tcnt_d;
            gnt_o         <= gnt_d;
            ack_o         <= ack_d;
            tx_start_o    <= start_d;
            tx_data_o     <= data_d;
            err_timeout_o <= err_d;
            word_cnt_o    <= cnt_d;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Randomized bench for link_tx_arbiter: drives requesters and a scripted link sender,
// predicting grants, acks, counts and errors from the arbitration rules.
module tb_link_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n, en, tx_done_i;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   gnt_o, ack_o;
    logic           tx_start_o, busy_o, err_timeout_o;
    logic [W-1:0]   tx_data_o;
    logic [15:0]    word_cnt_o;

    link_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_i(req_i), .data_i(data_i),
        .gnt_o(gnt_o), .ack_o(ack_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
        .tx_done_i(tx_done_i), .busy_o(busy_o), .err_timeout_o(err_timeout_o),
        .word_cnt_o(word_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_ptr = 0;
    int exp_cnt = 0;
    bit exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!$onehot0(gnt_o) || !$onehot0(ack_o)) begin
                failures++;
                $display("FAIL onehot gnt=%b ack=%b required at most one bit each", gnt_o, ack_o);
            end
        end
    end

    typedef struct {
        bit          seen;
        int          t;
        logic [N-1:0] gnt;
        logic [W-1:0] data;
        logic        start_mid;
        logic [N-1:0] ack;
        logic [N-1:0] gnt_end;
        logic        start_end;
        logic [15:0] cnt;
        logic        err;
        logic [N-1:0] ack_after;
    } obs_t;

    function automatic int pick(logic [N-1:0] r, int p);
`ifdef LINK_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] word_of(int k);
        return data_i[k*W +: W];
    endfunction

    task automatic model_done(input int w, input bit acked);
        bit upd = 1'b1;
`ifdef LINK_ARB_PRIO_EN
        if (w == 0) upd = 1'b0;
`endif
        if (upd) exp_ptr = (w + 1) % N;
        if (acked) exp_cnt = (exp_cnt + 1) % 65536;
        else exp_err = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; req_i = '0; tx_done_i = 1'b0;
        data_i = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 0; exp_cnt = 0; exp_err = 1'b0;
    endtask

    // Plays the link sender for one word: done after `delay` cycles, or never if tmo.
    task automatic serve(input int delay, input bit hold, input bit tmo, output obs_t o);
        o = '{default: 0};
        for (int i = 0; i < 20 && !o.seen; i++) begin
            @(negedge clk);
            if (tx_start_o) begin
                o.seen = 1'b1;
                o.t = cyc;
            end
        end
        if (!o.seen) return;
        o.gnt  = gnt_o;
        o.data = tx_data_o;
        if (tmo) begin
            repeat (TO - 1) @(negedge clk);
            o.start_mid = tx_start_o;
        end else begin
            repeat (delay - 1) @(negedge clk);
            o.start_mid = tx_start_o;
            tx_done_i = 1'b1;
        end
        @(negedge clk);
        o.ack = ack_o; o.gnt_end = gnt_o; o.start_end = tx_start_o;
        o.cnt = word_cnt_o; o.err = err_timeout_o;
        if (!hold) tx_done_i = 1'b0;
        @(negedge clk);
        o.ack_after = ack_o;
        tx_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req_i = '1; tx_done_i = 1'b0; data_i = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt_o, ack_o, tx_start_o, tx_data_o, busy_o, err_timeout_o, word_cnt_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs gnt=%b ack=%b start=%b data=%h busy=%b err=%b cnt=%0d required all 0",
                     gnt_o, ack_o, tx_start_o, tx_data_o, busy_o, err_timeout_o, word_cnt_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        obs_t o;
        do_reset();
        data_i[2*W +: W] = 32'hA5A5A5A7;
        req_i = 4'b0100;
        serve(5, 1'b1, 1'b0, o);
        checks++;
        if (!o.seen) begin failures++; $display("FAIL single_start got=none required=start"); end
        checks++;
        if (o.gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b required=0100", o.gnt); end
        checks++;
        if (o.data !== 32'hA5A5A5A7) begin failures++; $display("FAIL single_data got=%h required=a5a5a5a7", o.data); end
        checks++;
        if (o.start_mid !== 1'b1) begin failures++; $display("FAIL single_start_held got=%b required=1", o.start_mid); end
        checks++;
        if (o.ack !== 4'b0100 || o.ack_after !== 4'b0000) begin
            failures++; $display("FAIL single_ack got=%b,%b required=0100,0000", o.ack, o.ack_after);
        end
        checks++;
        if (o.cnt !== 16'd1 || o.start_end !== 1'b0 || o.gnt_end !== 4'b0000) begin
            failures++; $display("FAIL single_done cnt=%0d start=%b gnt=%b required=1,0,0000", o.cnt, o.start_end, o.gnt_end);
        end
    endtask

    task automatic test_round_robin();
        obs_t o;
        int w;
        do_reset();
        req_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            w = pick(req_i, exp_ptr);
            serve($urandom_range(1, 6), 1'(($urandom & 1)), 1'b0, o);
            checks++;
            if (o.gnt !== 4'(1 << w) || o.data !== word_of(w) || o.ack !== 4'(1 << w)) begin
                failures++;
                $display("FAIL rr_word%0d gnt=%b data=%h ack=%b required=%b,%h,%b",
                         k, o.gnt, o.data, o.ack, 4'(1 << w), word_of(w), 4'(1 << w));
            end
`ifndef LINK_ARB_PRIO_EN
            checks++;
            if (o.gnt !== 4'(1 << (k % 4))) begin
                failures++; $display("FAIL rr_order%0d got=%b required=%b", k, o.gnt, 4'(1 << (k % 4)));
            end
`endif
            model_done(w, 1'b1);
        end
        checks++;
        if (word_cnt_o !== 16'd8) begin failures++; $display("FAIL rr_count got=%0d required=8", word_cnt_o); end
    endtask

    task automatic test_timeout();
        obs_t o;
        int w;
        do_reset();
        req_i = 4'b0011;
        w = pick(req_i, exp_ptr);
        serve(0, 1'b0, 1'b1, o);
        checks++;
        if (o.gnt !== 4'(1 << w) || o.start_mid !== 1'b1 || o.start_end !== 1'b0) begin
            failures++; $display("FAIL tmo_window gnt=%b start16=%b start17=%b required=%b,1,0",
                                 o.gnt, o.start_mid, o.start_end, 4'(1 << w));
        end
        checks++;
        if (o.err !== 1'b1 || o.ack !== 4'b0000 || o.cnt !== 16'd0) begin
            failures++; $display("FAIL tmo_abort err=%b ack=%b cnt=%0d required=1,0000,0", o.err, o.ack, o.cnt);
        end
        model_done(w, 1'b0);
        w = pick(req_i, exp_ptr);
        serve(3, 1'b0, 1'b0, o);
        checks++;
        if (o.gnt !== 4'(1 << w) || o.ack !== 4'(1 << w)) begin
            failures++; $display("FAIL tmo_next gnt=%b ack=%b required=%b", o.gnt, o.ack, 4'(1 << w));
        end
        checks++;
        if (err_timeout_o !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b required=1", err_timeout_o); end
    endtask

    task automatic test_done_at_limit();
        obs_t o;
        do_reset();
        req_i = 4'b0100;
        serve(TO, 1'b0, 1'b0, o);
        checks++;
        if (o.ack !== 4'b0100 || o.err !== 1'b0 || o.cnt !== 16'd1) begin
            failures++; $display("FAIL done_at_limit ack=%b err=%b cnt=%0d required=0100,0,1", o.ack, o.err, o.cnt);
        end
    endtask

    task automatic test_enable();
        int starts = 0;
        bit seen = 1'b0;
        logic [N-1:0] a;
        do_reset();
        en = 1'b0;
        req_i = 4'b1111;
        repeat (20) begin @(negedge clk); if (tx_start_o) starts++; end
        checks++;
        if (starts != 0) begin failures++; $display("FAIL en_low_starts got=%0d required=0", starts); end
        en = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = tx_start_o; end
        en = 1'b0;
        repeat (2) @(negedge clk);
        tx_done_i = 1'b1;
        @(negedge clk);
        a = ack_o;
        tx_done_i = 1'b0;
        checks++;
        if (!seen || a !== 4'b0001) begin
            failures++; $display("FAIL en_inflight seen=%b ack=%b required=1,0001", seen, a);
        end
        starts = 0;
        repeat (10) begin @(negedge clk); if (tx_start_o) starts++; end
        checks++;
        if (starts != 0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL en_drop starts=%0d busy=%b required=0,0", starts, busy_o);
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit seen = 1'b0;
        do_reset();
        req_i = 4'b0100;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = tx_start_o; end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        tx_done_i = 1'b1;
        @(negedge clk);
        checks++;
        if (!seen || {gnt_o, ack_o, tx_start_o, tx_data_o, busy_o, err_timeout_o, word_cnt_o} !== '0) begin
            failures++; $display("FAIL reset_mid seen=%b gnt=%b ack=%b start=%b busy=%b cnt=%0d required all 0",
                                 seen, gnt_o, ack_o, tx_start_o, busy_o, word_cnt_o);
        end
        rst_n = 1'b1;
        tx_done_i = 1'b0;
        exp_ptr = 0; exp_cnt = 0;
        req_i = 4'b1111;
        serve(2, 1'b0, 1'b0, o);
        checks++;
        if (o.gnt !== 4'b0001 || o.ack !== 4'b0001 || o.cnt !== 16'd1) begin
            failures++; $display("FAIL reset_mid_first gnt=%b ack=%b cnt=%0d required=0001,0001,1", o.gnt, o.ack, o.cnt);
        end
    endtask

    task automatic test_prio();
        obs_t o;
        int w;
        int order[4];
`ifdef LINK_ARB_PRIO_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 1, 3, 0};
`endif
        do_reset();
        req_i = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            w = pick(req_i, exp_ptr);
            serve(2, 1'b0, 1'b0, o);
            checks++;
            if (o.gnt !== 4'(1 << w) || o.gnt !== 4'(1 << order[k])) begin
                failures++; $display("FAIL prio_word%0d got=%b required=%b", k, o.gnt, 4'(1 << order[k]));
            end
            model_done(w, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        do_reset();
        req_i = 4'b1111;
        serve(1, 1'b0, 1'b0, o1);
        serve(1, 1'b0, 1'b0, o2);
        checks++;
        if (!o1.seen || !o2.seen || (o2.t - o1.t) != 3) begin
            failures++; $display("FAIL b2b_spacing got=%0d required=3", o2.t - o1.t);
        end
    endtask

    task automatic test_random();
        obs_t o;
        int w;
        bit tmo;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            req_i = 4'($urandom_range(1, 15));
            data_i = {$urandom, $urandom, $urandom, $urandom};
            w = pick(req_i, exp_ptr);
            tmo = ($urandom_range(0, 9) == 0);
            serve($urandom_range(1, 8), 1'(($urandom & 1)), tmo, o);
            model_done(w, !tmo);
            checks++;
            if (!o.seen || o.gnt !== 4'(1 << w) || o.data !== word_of(w)) begin
                failures++; $display("FAIL rand%0d_grant seen=%b gnt=%b data=%h required=%b,%h",
                                     k, o.seen, o.gnt, o.data, 4'(1 << w), word_of(w));
            end
            checks++;
            if (o.ack !== (tmo ? 4'b0000 : 4'(1 << w)) || o.cnt !== 16'(exp_cnt) || o.err !== exp_err) begin
                failures++; $display("FAIL rand%0d_result ack=%b cnt=%0d err=%b required tmo=%b cnt=%0d err=%b",
                                     k, o.ack, o.cnt, o.err, tmo, exp_cnt, exp_err);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req_i = '0; data_i = '0; tx_done_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_at_limit();
        test_enable();
        test_reset_mid();
        test_prio();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/link_tx_arbiter.md
Name: link_tx_arbiter

Overview:
- Shares the single FPGA-to-FPGA transmit path between NUM_REQ local requesters, one 32-bit word at a time.
- Drives the sender's start/data inputs and consumes its done strobe.
- Arbitration is round-robin; a watchdog aborts transfers the link never completes.
- Sits between on-chip data producers and the link sender instance in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, word width; matches the link data bus.
- TIMEOUT, 1023, maximum cycles in SEND waiting for tx_done_i before abort (>= 2).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  arbitration enable; low blocks new grants only.
- req_i  in  NUM_REQ  per-requester word-pending flag; held high until the matching ack_o.
- data_i  in  NUM_REQ*DATA_W  packed words; requester k occupies bits [k*DATA_W +: DATA_W].
- gnt_o  out  NUM_REQ  one-hot current owner; all zero when idle.
- ack_o  out  NUM_REQ  one-cycle pulse to the owner when its word has completed.
- tx_start_o  out  1  start to the link sender.
- tx_data_o  out  DATA_W  word presented to the link sender.
- tx_done_i  in  1  sender completion; level, may stay high until start drops.
- busy_o  out  1  high in any state other than IDLE.
- err_timeout_o  out  1  sticky abort flag; cleared only by reset.
- word_cnt_o  out  16  count of completed (acked) words; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_n low at a clk edge) sets all outputs to 0, state to IDLE, round-robin pointer to 0, and the timeout counter to 0. Reset mid-transfer aborts immediately with no ack.
- FSM states: IDLE, SEND, RELEASE.
- IDLE:
  - If en && |req_i, pick the winner: the first set req_i scanning upward from the pointer and wrapping at NUM_REQ-1 -> 0.
  - Latch data_i[winner] into tx_data_o, set gnt_o one-hot and tx_start_o=1, clear the timeout counter, go to SEND.
  - Latency: req_i sampled high at edge N -> tx_start_o high after edge N (one cycle).
- SEND:
  - tx_start_o, tx_data_o and gnt_o are held stable.
  - If tx_done_i: pulse ack_o[winner] for one cycle, drop tx_start_o, increment word_cnt_o, set the pointer to winner+1 (mod NUM_REQ), go to RELEASE.
  - Else if the counter reaches TIMEOUT-1: drop tx_start_o, set err_timeout_o, no ack, no count increment; the pointer still advances to winner+1 so a stuck requester cannot starve others. Go to RELEASE.
  - Else increment the counter.
- RELEASE:
  - gnt_o is cleared on entry.
  - Remain until tx_done_i is low, then go to IDLE. No arbitration takes place in this state.
  - Minimum spacing between two starts is therefore 3 cycles.
- Requester dropping req_i during SEND: the latched word still completes and the ack is still issued. A requester whose req_i is low is never granted.
- en low during SEND/RELEASE: the in-flight word completes normally; IDLE then waits for en.
- Only one ack_o bit is ever high, and only for a single cycle.
- Simultaneous tx_done_i and timeout expiry on the same edge: done wins (acked, no error).

Optional Feature:
- Macro LINK_ARB_PRIO_EN.
- Defined: requester 0 is strict high priority. If req_i[0] is high in IDLE, it wins regardless of the pointer, and the pointer is not updated. The remaining requesters are round-robin among themselves as above.
- Undefined: pure round-robin over all NUM_REQ; no requester is privileged.

Test Plan:
- Single requester: req_i=4'b0100, data_i[2]=32'hA5A5A5A7, sender done 5 cycles after start -> gnt_o=4'b0100, tx_data_o=32'hA5A5A5A7, one ack_o[2] pulse, word_cnt_o=1.
- All four request continuously, 8 words -> grant order 0,1,2,3,0,1,2,3; word_cnt_o=8; never two gnt_o bits high.
- tx_done_i never asserted, TIMEOUT=16 -> tx_start_o drops after 16 cycles in SEND, err_timeout_o=1, no ack, the next requester is granted afterwards.
- en low with req_i=4'b1111 -> no tx_start_o for 20 cycles. With en raised mid-transfer, then lowered: the current word is acked, and no new grant follows.
- Synchronous reset asserted 2 cycles into SEND -> on the next edge all outputs 0 and no ack. After release, requester 0 is granted first.
- With LINK_ARB_PRIO_EN, req_i=4'b1011 held -> requester 0 granted on every arbitration; without the macro -> order 0,1,3,0.
